// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, receiver state type and frame check helper for
// the PS/2 keyboard receiver.
//   PS2_FRAME_BITS  bits per device-to-host frame (start, 8 data, parity, stop)
//   PS2_*_IDX       bit positions of the framing fields inside a received frame
//   ps2_rx_state_e  frame receiver state
//   frame_good()    start/parity/stop check on a fully shifted frame
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_START_IDX  = 0;
    localparam int PS2_PAR_IDX    = 9;
    localparam int PS2_STOP_IDX   = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } ps2_rx_state_e;

    // Odd parity: the eight data bits plus the parity bit must XOR to 1.
    function automatic logic frame_good(input logic [PS2_FRAME_BITS-1:0] f);
        return (f[PS2_START_IDX] == 1'b0) &&
               (f[PS2_STOP_IDX] == 1'b1) &&
               (^f[PS2_PAR_IDX:1] == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo: show-ahead byte FIFO for received scan codes.
//   clk, rst  system clock, synchronous active-high reset (pointers only)
//   wr_en     push wr_data; ignored while full unless a pop happens together
//   wr_data   byte to push
//   rd_en     pop the head byte; ignored while empty
//   rd_data   head byte, read combinationally from registered storage
//   empty     no bytes stored
//   full      DEPTH bytes stored
module ps2_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit separates full from empty when the index bits match.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [7:0]   mem [DEPTH];
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = wr_en && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 device-to-host receiver with byte FIFO.
//   clk, rst   system clock, synchronous active-high reset
//   ps2_clk    raw PS/2 clock pin (asynchronous)
//   ps2_data   raw PS/2 data pin (asynchronous)
//   rd_en      pop strobe
//   data       FIFO head byte (8'h00 while empty)
//   valid      FIFO non-empty
//   overflow   sticky, a good byte was dropped because the FIFO was full
//   frame_err  one-cycle pulse when a completed frame fails its checks
//   rx_state   frame receiver state, for observation
//
// Read handshake: a byte moves downstream on every clk edge where valid and
// rd_en are both 1; rd_en while valid is 0 does nothing, and data holds
// steady while valid is 1 and no pop occurs.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    input  logic          rd_en,
    output logic [7:0]    data,
    output logic          valid,
    output logic          overflow,
    output logic          frame_err,
    output ps2_rx_state_e rx_state
);

    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0]    clk_sync;
    logic [SYNC_STAGES-1:0]    data_sync;
    logic                      clk_cur;
    logic                      data_cur;
    logic                      clk_prev;
    logic                      strobe;
    logic [PS2_FRAME_BITS-1:0] shift_reg;
    logic [3:0]                bit_cnt;
    logic [IW-1:0]             idle_cnt;
    logic                      frame_done;
    logic                      last_bit;
    logic                      timeout;
    logic                      good;
    logic                      push;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic [7:0]                fifo_data;
    ps2_rx_state_e             state;
    ps2_rx_state_e             next_state;

    assign clk_cur  = clk_sync[SYNC_STAGES-1];
    assign data_cur = data_sync[SYNC_STAGES-1];
    assign last_bit = strobe && (bit_cnt == 4'(PS2_FRAME_BITS - 1));
    assign timeout  = (state == RECV) && (idle_cnt == IW'(TIMEOUT_CYCLES));

    // Frame check runs the cycle after the 11th strobe, once the last bit has shifted in.
    assign good      = frame_good(shift_reg);
    assign push      = frame_done && good;
    assign frame_err = frame_done && !good;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync   <= '1;
            data_sync  <= '1;
            clk_prev   <= 1'b1;
            strobe     <= 1'b0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev   <= clk_cur;
            strobe     <= clk_prev && !clk_cur;
            frame_done <= last_bit;
            if (strobe) begin
                shift_reg <= {data_cur, shift_reg[PS2_FRAME_BITS-1:1]};
                bit_cnt   <= last_bit ? 4'd0 : bit_cnt + 4'd1;
                idle_cnt  <= '0;
            end else if (timeout) begin
                bit_cnt  <= '0;
                idle_cnt <= '0;
            end else if (state == RECV) begin
                idle_cnt <= idle_cnt + IW'(1);
            end
            // A pop in the same cycle makes room, so that push is not a drop.
            if (push && fifo_full && !rd_en) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (strobe) next_state = RECV;
            RECV: if (last_bit || (timeout && !strobe)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (shift_reg[8:1]),
        .rd_en   (rd_en),
        .rd_data (fifo_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign valid    = !fifo_empty;
    assign data     = fifo_empty ? 8'h00 : fifo_data;
    assign rx_state = state;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int FIFO_DEPTH  = 8;
    localparam int SYNC_STAGES = 3;
    localparam int TIMEOUT     = 500;
    localparam int HALF        = 20;   // PS/2 half period in clk cycles

    logic          clk;
    logic          rst;
    logic          ps2_clk;
    logic          ps2_data;
    logic          rd_en;
    logic [7:0]    data;
    logic          valid;
    logic          overflow;
    logic          frame_err;
    ps2_rx_state_e rx_state;

    int n_cmp;
    int n_bad;
    int err_cnt;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] byte_val;
        logic       bad_par;
        int         exp_err;
        logic       exp_valid;
    } vec_t;

    ps2_keyboard_rx #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .data      (data),
        .valid     (valid),
        .overflow  (overflow),
        .frame_err (frame_err),
        .rx_state  (rx_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver
    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad);
        logic p;
        p = (~^b) ^ bad;
        return {1'b1, p, b, 1'b0};
    endfunction

    // Sends the first n bits of frame f. With pop_at_commit, rd_en is held
    // high for exactly the cycle in which the last bit's byte is pushed:
    // SYNC_STAGES cycles to see the fall, one to strobe, one to check.
    task automatic send_bits(input logic [10:0] f, input int n, input bit pop_at_commit);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (pop_at_commit && i == n - 1) begin
                repeat (SYNC_STAGES + 2) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                repeat (HALF - SYNC_STAGES - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(make_frame(b, 1'b0), 11, 1'b0);
        exp_q.push_back(b);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard: head of exp_q must be on data with valid high.
    task automatic read_check(input string name);
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check({name, "_valid"}, valid, 1);
        check({name, "_data"}, data, e);
        pop();
    endtask

    vec_t vecs[6];

    initial begin
        int err0;
        n_cmp    = 0;
        n_bad    = 0;
        err_cnt  = 0;
        rd_en    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;

        vecs[0] = '{8'h1C, 1'b0, 0, 1'b1};
        vecs[1] = '{8'h1C, 1'b1, 1, 1'b0};
        vecs[2] = '{8'hF0, 1'b0, 0, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 0, 1'b1};
        vecs[4] = '{8'hFF, 1'b0, 0, 1'b1};
        vecs[5] = '{8'h7E, 1'b1, 1, 1'b0};

        // Reset state
        do_reset();
        check("rst_valid", valid, 0);
        check("rst_data", data, 8'h00);
        check("rst_overflow", overflow, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_state", rx_state, IDLE);

        // Table-driven single frames
        for (int i = 0; i < 6; i++) begin
            err0 = err_cnt;
            send_bits(make_frame(vecs[i].byte_val, vecs[i].bad_par), 11, 1'b0);
            check($sformatf("vec%0d_err", i), err_cnt - err0, vecs[i].exp_err);
            check($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                exp_q.push_back(vecs[i].byte_val);
                read_check($sformatf("vec%0d", i));
                check($sformatf("vec%0d_empty", i), valid, 0);
            end
        end

        // Overflow: nine frames, no reads
        do_reset();
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        check("ovf_before", overflow, 0);
        send_bits(make_frame(8'h09, 1'b0), 11, 1'b0);
        check("ovf_after", overflow, 1);
        for (int i = 1; i <= 8; i++) read_check($sformatf("ovf_rd%0d", i));
        check("ovf_empty", valid, 0);
        check("ovf_sticky", overflow, 1);

        // Push into full FIFO while popping in the commit cycle
        do_reset();
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        void'(exp_q.pop_front());
        exp_q.push_back(8'h09);
        send_bits(make_frame(8'h09, 1'b0), 11, 1'b1);
        check("col_overflow", overflow, 0);
        for (int i = 2; i <= 9; i++) read_check($sformatf("col_rd%0d", i));
        check("col_empty", valid, 0);

        // Timeout discards a partial frame silently
        do_reset();
        err0 = err_cnt;
        send_bits(make_frame(8'hAA, 1'b0), 5, 1'b0);
        check("to_recv", rx_state, RECV);
        repeat (TIMEOUT + 100) @(negedge clk);
        check("to_idle", rx_state, IDLE);
        check("to_err", err_cnt - err0, 0);
        send_byte(8'h2A);
        check("to_err2", err_cnt - err0, 0);
        read_check("to_2a");

        // Reset in the middle of a frame, with a byte already buffered
        do_reset();
        send_byte(8'h55);
        send_bits(make_frame(8'h99, 1'b0), 7, 1'b0);
        do_reset();
        check("mr_valid", valid, 0);
        check("mr_data", data, 8'h00);
        err0 = err_cnt;
        send_byte(8'h33);
        check("mr_err", err_cnt - err0, 0);
        read_check("mr_33");
        check("mr_empty", valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- PS/2 device-to-host receiver sitting directly behind the top-level ps2_clk/ps2_data pins.
- Synchronises the asynchronous PS/2 lines into the system clock domain and deserialises 11-bit frames.
- Checks start, parity and stop bits, and buffers good scan-code bytes in a small FIFO.
- Downstream consumers (scan-code decoder, seg/led display logic) pop bytes with a simple read strobe.

Parameters:
- FIFO_DEPTH, 8, number of buffered bytes; power of two, 2..64.
- SYNC_STAGES, 3, flops in each input synchroniser; minimum 2.
- TIMEOUT_CYCLES, 50000, idle clk cycles mid-frame before the partial frame is discarded (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
- ps2_data  input  1  raw PS/2 data pin, asynchronous.
- rd_en  input  1  pop strobe; honoured only when valid=1.
- data  output  8  FIFO head byte; valid only while valid=1.
- valid  output  1  FIFO non-empty.
- overflow  output  1  sticky; set when a good byte arrives with the FIFO full.
- frame_err  output  1  one-cycle pulse on a start, parity or stop error.

Behaviour:
- Clocking and reset:
  - Single clock domain: clk. Reset is synchronous and active-high on rst.
  - All state clears on rst: synchronisers to 1, bit counter 0, FIFO pointers 0, overflow 0.
  - Output reset values: valid=0, data=8'h00, frame_err=0, overflow=0.
  - rst mid-frame drops the partial frame and empties the FIFO.
- Synchronisation and sampling:
  - Both pins pass through SYNC_STAGES flops.
  - A sample strobe fires one cycle after the synchronised ps2_clk shows a falling edge (prev=1, cur=0).
  - On each strobe, the synchronised ps2_data shifts into an 11-bit register LSB-first and bit_cnt increments.
- Frame layout: bit0 start (must be 0), bits1..8 data LSB-first, bit9 odd parity, bit10 stop (must be 1).
- Frame states: IDLE, RECV.
  - IDLE -> RECV on the first strobe.
  - RECV -> IDLE on the 11th strobe or on timeout.
- Frame completion, on the cycle after the 11th strobe:
  - Good frame means start==0, stop==1, and XOR of data+parity bits ==1.
  - Good frame: push the byte.
  - Bad frame: frame_err=1 for exactly one cycle, nothing pushed.
  - In either case bit_cnt returns to 0.
- Timeout:
  - In RECV, an idle counter restarts on every strobe.
  - When it reaches TIMEOUT_CYCLES, the partial frame is discarded, state returns to IDLE, and frame_err is not asserted.
- Latency: a good byte appears at data with valid=1 two cycles after the final strobe.
- FIFO:
  - Show-ahead: data = mem[rd_ptr] combinationally from registered storage.
  - Pointers are log2(FIFO_DEPTH)+1 bits. Full when the MSBs differ and the rest are equal; empty when all bits are equal.
  - rd_en with empty: ignored, no pointer movement.
  - Push with full: byte dropped, overflow set; overflow clears only on rst.
  - Simultaneous push and pop when full: both occur, overflow not set, occupancy unchanged.
  - Simultaneous push and pop when empty: push occurs, pop ignored.
  - Pointer wrap-around is natural modulo 2*FIFO_DEPTH.

Decomposition:
- Package ps2_pkg:
  - constants PS2_FRAME_BITS=11, PS2_START_IDX=0, PS2_PAR_IDX=9, PS2_STOP_IDX=10;
  - state enum ps2_rx_state_e {IDLE, RECV}.
- One sub-module: ps2_byte_fifo (parameter DEPTH; ports clk, rst, wr_en, wr_data, rd_en, rd_data, empty, full).
- Synchroniser, deserialiser and frame checker stay inline in ps2_keyboard_rx.

Test Plan:
- Reset: hold rst 2 cycles with the pins idle-high -> valid=0, data=8'h00, overflow=0, frame_err=0.
- Single frame: send 0x1C with parity 0 and stop 1, ps2_clk period 60 us -> valid rises, data=8'h1C. Pulse rd_en one cycle -> valid=0.
- Bad parity: send 0x1C with parity 1 -> exactly one frame_err pulse, valid stays 0. Then send 0xF0 -> data=8'hF0.
- Overflow: send 9 frames 0x01..0x09 with no reads -> overflow=1 after the 9th. Reads return 0x01..0x08, then valid=0.
- Full push/pop collision: FIFO full, assert rd_en in the same cycle the 9th good byte commits -> overflow=0; subsequent reads return 0x02..0x09.
- Timeout and mid-frame reset:
  - 5 clock pulses then idle for >TIMEOUT_CYCLES, then a full 0x2A frame -> data=8'h2A, no frame_err.
  - Separately, assert rst after bit 6 -> after release, the next full 0x33 frame is received correctly.
